// File: rtl/line_mem_responder_pkg.sv
// rtl/line_mem_responder_pkg.sv - shared line geometry, FSM states and line type for the line memory responder
package mem_if_pkg;

  localparam int LINE_W   = 256;
  localparam int DEPTH    = 512;
  localparam int IDX_W    = 9;
  localparam int ADDR_LSB = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  typedef logic [LINE_W-1:0] line_t;

endpackage

// File: rtl/line_mem_responder_if.sv
// rtl/line_mem_responder_if.sv - cache-line request/ack bus between the dcache miss engine and the responder
interface line_mem_responder_if;
  import mem_if_pkg::*;

  logic [31:0] addr_i;
  line_t       data_i;
  logic        enable_i;
  logic        write_i;
  logic        ack_o;
  line_t       data_o;

  modport master (
    output addr_i, data_i, enable_i, write_i,
    input  ack_o, data_o
  );

  modport slave (
    input  addr_i, data_i, enable_i, write_i,
    output ack_o, data_o
  );

endinterface

// File: rtl/line_mem_responder_sram.sv
// rtl/line_mem_responder_sram.sv - single-port line array, synchronous write, registered read, no reset
module line_sram
  import mem_if_pkg::*;
(
  input  logic             clk_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [IDX_W-1:0] addr_i,
  input  line_t            wdata_i,
  output line_t            rdata_o
);

  line_t memory [DEPTH];
  line_t rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      memory[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= memory[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/line_mem_responder.sv
// rtl/line_mem_responder.sv - fixed-latency cache-line memory responder; MEM_STATS_EN adds read/write counters
module line_mem_responder
  import mem_if_pkg::*;
#(
  parameter int LATENCY = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  line_mem_responder_if.slave bus
`ifdef MEM_STATS_EN
  ,
  output logic [31:0] rd_cnt_o,
  output logic [31:0] wr_cnt_o
`endif
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  line_t              wdata_q, wdata_d;
  logic               wr_q, wr_d;
  logic               fire;
  logic               rd_valid_q;

  logic [IDX_W-1:0]   addr_idx;
  logic [IDX_W-1:0]   op_idx;
  line_t              op_wdata;
  logic               op_wr;
  logic               sram_we, sram_re;
  line_t              sram_rdata;
  logic               unused_addr_bits;

  assign addr_idx         = bus.addr_i[ADDR_LSB+IDX_W-1:ADDR_LSB];
  assign unused_addr_bits = ^{bus.addr_i[31:ADDR_LSB+IDX_W], bus.addr_i[ADDR_LSB-1:0]};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
    end
  end

  // fire marks the edge entering ACK: the array access happens on that edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    fire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable_i) begin
          idx_d   = addr_idx;
          wdata_d = bus.data_i;
          wr_d    = bus.write_i;
          cnt_d   = CNT_W'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d = ACK;
            fire    = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ACK;
          fire    = 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With LATENCY=1 the access happens on the accepting edge, before the latches are loaded.
  assign op_idx   = (state_q == IDLE) ? addr_idx    : idx_q;
  assign op_wdata = (state_q == IDLE) ? bus.data_i  : wdata_q;
  assign op_wr    = (state_q == IDLE) ? bus.write_i : wr_q;
  assign sram_we  = fire & op_wr;
  assign sram_re  = fire & ~op_wr;

  line_sram u_sram (
    .clk_i   (clk_i),
    .we_i    (sram_we),
    .re_i    (sram_re),
    .addr_i  (op_idx),
    .wdata_i (op_wdata),
    .rdata_o (sram_rdata)
  );

  // The array read register has no reset, so data_o is masked to zero until the first read ack.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_valid_q <= 1'b0;
    end else if (sram_re) begin
      rd_valid_q <= 1'b1;
    end
  end

  assign bus.ack_o  = (state_q == ACK);
  assign bus.data_o = rd_valid_q ? sram_rdata : '0;

`ifdef MEM_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (sram_re) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (sram_we) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
// tb/tb_line_mem_responder.sv - directed self-checking bench for line_mem_responder
module tb_line_mem_responder;
  import mem_if_pkg::*;

  localparam int LAT = 10;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  line_mem_responder_if bus ();

`ifdef MEM_STATS_EN
  logic [31:0] rd_cnt, wr_cnt;
`endif

  line_mem_responder #(.LATENCY(LAT)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.slave)
`ifdef MEM_STATS_EN
    ,
    .rd_cnt_o (rd_cnt),
    .wr_cnt_o (wr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // lat counts edges from the accepting edge (edge 1) to the edge after which ack_o is seen high.
  task automatic do_req(input logic wr, input logic [31:0] a, input line_t d,
                        input bit scramble, output int lat, output line_t rd);
    lat = 0;
    rd  = '0;
    bus.enable_i = 1'b1;
    bus.write_i  = wr;
    bus.addr_i   = a;
    bus.data_i   = d;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (scramble && k == 1) begin
        bus.addr_i  = a ^ 32'h60;
        bus.data_i  = ~d;
        bus.write_i = ~wr;
      end
      if (bus.ack_o) begin
        lat = k;
        rd  = bus.data_o;
        break;
      end
    end
    bus.enable_i = 1'b0;
    if (lat != 0) begin
      @(negedge clk);
      tests++;
      if (bus.ack_o !== 1'b0) begin
        $display("FAIL ack_one_cycle: ack_o=%b required 0", bus.ack_o);
        fails++;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.enable_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (bus.ack_o !== 1'b0 || bus.data_o !== '0) begin
      $display("FAIL reset_outputs: ack_o=%b data_o=%h required 0/0", bus.ack_o, bus.data_o);
      fails++;
    end
    rst_n = 1'b1;
    begin
      int acks;
      acks = 0;
      repeat (20) begin
        @(negedge clk);
        if (bus.ack_o) acks++;
      end
      tests++;
      if (acks != 0) begin
        $display("FAIL idle_no_ack: acks=%0d required 0", acks);
        fails++;
      end
    end
  endtask

  task automatic test_preloaded_read();
    int    lat;
    line_t rd;
    dut.u_sram.memory[0] = 256'h5;
    do_req(1'b0, 32'h0, '0, 1'b0, lat, rd);
    tests++;
    if (lat != LAT) begin
      $display("FAIL read_latency: edges=%0d required %0d", lat, LAT);
      fails++;
    end
    tests++;
    if (rd !== 256'h5) begin
      $display("FAIL read_data: data_o=%h required 5", rd);
      fails++;
    end
  endtask

  task automatic test_write_read();
    int    lat;
    line_t rd;
    line_t pat;
    pat = {8{32'hDEADBEEF}};
    do_req(1'b1, 32'h400, pat, 1'b0, lat, rd);
    tests++;
    if (lat != LAT) begin
      $display("FAIL write_latency: edges=%0d required %0d", lat, LAT);
      fails++;
    end
    tests++;
    if (dut.u_sram.memory[32] !== pat) begin
      $display("FAIL write_commit: memory[32]=%h required %h", dut.u_sram.memory[32], pat);
      fails++;
    end
    tests++;
    if (bus.data_o !== 256'h5) begin
      $display("FAIL data_hold_on_write: data_o=%h required 5", bus.data_o);
      fails++;
    end
    do_req(1'b0, 32'h400, '0, 1'b0, lat, rd);
    tests++;
    if (lat != LAT || rd !== pat) begin
      $display("FAIL readback: edges=%0d data=%h required %0d/%h", lat, rd, LAT, pat);
      fails++;
    end
  endtask

  task automatic test_latched_wrap();
    int    lat;
    line_t rd;
    line_t d1, keep2;
    d1    = {4{64'h0123_4567_89AB_CDEF}};
    keep2 = {8{32'h2222_2222}};
    dut.u_sram.memory[2] = keep2;
    do_req(1'b1, 32'h20, d1, 1'b1, lat, rd);
    tests++;
    if (dut.u_sram.memory[1] !== d1) begin
      $display("FAIL latched_data: memory[1]=%h required %h", dut.u_sram.memory[1], d1);
      fails++;
    end
    tests++;
    if (dut.u_sram.memory[2] !== keep2) begin
      $display("FAIL latched_addr: memory[2]=%h required %h", dut.u_sram.memory[2], keep2);
      fails++;
    end
    do_req(1'b0, 32'h4020, '0, 1'b0, lat, rd);
    tests++;
    if (lat != LAT || rd !== d1) begin
      $display("FAIL wrap_read: edges=%0d data=%h required %0d/%h", lat, rd, LAT, d1);
      fails++;
    end
  endtask

  task automatic test_reset_mid_request();
    int    lat, acks;
    line_t rd;
    line_t old3;
    old3 = {8{32'h3333_CAFE}};
    dut.u_sram.memory[3] = old3;
    bus.enable_i = 1'b1;
    bus.write_i  = 1'b1;
    bus.addr_i   = 32'h60;
    bus.data_i   = '1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    bus.enable_i = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.data_o !== '0) begin
      $display("FAIL reset_clears_data: data_o=%h required 0", bus.data_o);
      fails++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.ack_o) acks++;
    end
    tests++;
    if (acks != 0) begin
      $display("FAIL abort_no_ack: acks=%0d required 0", acks);
      fails++;
    end
    tests++;
    if (dut.u_sram.memory[3] !== old3) begin
      $display("FAIL abort_no_write: memory[3]=%h required %h", dut.u_sram.memory[3], old3);
      fails++;
    end
    do_req(1'b0, 32'h60, '0, 1'b0, lat, rd);
    tests++;
    if (lat != LAT || rd !== old3) begin
      $display("FAIL read_after_abort: edges=%0d data=%h required %0d/%h", lat, rd, LAT, old3);
      fails++;
    end
  endtask

`ifdef MEM_STATS_EN
  task automatic test_stats();
    int    lat;
    line_t rd;
    apply_reset();
    for (int i = 0; i < 3; i++) do_req(1'b0, 32'(i * 32), '0, 1'b0, lat, rd);
    for (int i = 0; i < 2; i++) do_req(1'b1, 32'h800 + 32'(i * 32), line_t'(i), 1'b0, lat, rd);
    tests++;
    if (rd_cnt !== 32'd3 || wr_cnt !== 32'd2) begin
      $display("FAIL stats_count: rd=%0d wr=%0d required 3/2", rd_cnt, wr_cnt);
      fails++;
    end
    apply_reset();
    tests++;
    if (rd_cnt !== 32'd0 || wr_cnt !== 32'd0) begin
      $display("FAIL stats_reset: rd=%0d wr=%0d required 0/0", rd_cnt, wr_cnt);
      fails++;
    end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.enable_i = 1'b0;
    bus.write_i  = 1'b0;
    bus.addr_i   = '0;
    bus.data_i   = '0;
    @(negedge clk);
    test_reset();
    test_preloaded_read();
    test_write_read();
    test_latched_wrap();
    test_reset_mid_request();
`ifdef MEM_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
